// File: rtl/gf180_ram_banked_ctrl_if.sv
// Request/response bus of the banked SRAM controller.
// The master issues valid/ready requests and takes fixed-latency read responses.
interface gf180_ram_banked_ctrl_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) ();
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH/8-1:0]   req_wmask;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic                      rsp_valid;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      init_done;

    modport master (
        output req_valid, req_write, req_addr, req_wmask, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, init_done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wmask, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, init_done
    );
endinterface

// File: rtl/gf180_ram_banked_ctrl.sv
// Banked single-port SRAM controller: decodes upper address bits to 512-row banks,
// returns read data one cycle after acceptance and optionally zero-fills after reset.
module gf180_ram_banked_ctrl #(
    parameter int ADDR_WIDTH       = 11,
    parameter int DATA_WIDTH       = 32,
    parameter int MACRO_ADDR_WIDTH = 9,
    parameter int CLEAR_ON_RESET   = 1
) (
`ifdef USE_POWER_PINS
    inout wire                     vdd,
    inout wire                     vss,
`endif
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    gf180_ram_banked_ctrl_if.slave bus
);
    localparam int BANK_BITS = ADDR_WIDTH - MACRO_ADDR_WIDTH;
    localparam int NUM_BANKS = 2 ** BANK_BITS;
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int SEL_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROWS      = 2 ** MACRO_ADDR_WIDTH;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]                  r_state;
    logic [MACRO_ADDR_WIDTH-1:0] r_clr_row;
    logic                        r_rsp_valid;
    logic [SEL_W-1:0]            r_rd_sel;
    logic [DATA_WIDTH-1:0]       r_rdata_hold;

    logic                        w_ready;
    logic                        w_accept;
    logic                        w_rd_accept;
    logic                        w_clearing;
    logic [SEL_W-1:0]            w_bank_idx;
    logic [MACRO_ADDR_WIDTH-1:0] w_row;
    logic [NUM_BANKS-1:0]        w_bank_ce;
    logic                        w_bank_we;
    logic [NUM_BYTES-1:0]        w_bank_mask;
    logic [MACRO_ADDR_WIDTH-1:0] w_bank_addr;
    logic [DATA_WIDTH-1:0]       w_bank_wdata;
    logic [DATA_WIDTH-1:0]       w_bank_q [NUM_BANKS];
    logic [DATA_WIDTH-1:0]       w_rsp_data;

    assign w_ready     = (r_state == ST_READY);
    assign w_accept    = bus.req_valid && w_ready;
    assign w_rd_accept = w_accept && !bus.req_write;
    // With clearing disabled the CLEAR state is a single pass-through cycle that writes nothing.
    assign w_clearing  = (r_state == ST_CLEAR) && (CLEAR_ON_RESET != 0);
    assign w_row       = bus.req_addr[MACRO_ADDR_WIDTH-1:0];

    generate
        if (BANK_BITS > 0) begin : g_bank_decode
            assign w_bank_idx = bus.req_addr[ADDR_WIDTH-1:MACRO_ADDR_WIDTH];
        end else begin : g_single_bank
            assign w_bank_idx = '0;
        end
    endgenerate

    always_comb begin
        w_bank_ce    = '0;
        w_bank_we    = 1'b0;
        w_bank_mask  = '0;
        w_bank_addr  = w_row;
        w_bank_wdata = bus.req_wdata;
        if (w_clearing) begin
            w_bank_ce    = '1;
            w_bank_we    = 1'b1;
            w_bank_mask  = '1;
            w_bank_addr  = r_clr_row;
            w_bank_wdata = '0;
        end else if (w_accept) begin
            w_bank_ce[w_bank_idx] = 1'b1;
            w_bank_we             = bus.req_write;
            w_bank_mask           = bus.req_wmask;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_row <= '0;
        end else if (r_state == ST_CLEAR) begin
            if ((CLEAR_ON_RESET == 0) || (r_clr_row == MACRO_ADDR_WIDTH'(ROWS - 1))) begin
                r_state <= ST_READY;
            end else begin
                r_clr_row <= r_clr_row + 1'b1;
            end
        end
    end

    // The bank select is registered so the returned word comes from the bank actually read,
    // whatever address is presented in the response cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rsp_valid  <= 1'b0;
            r_rd_sel     <= '0;
            r_rdata_hold <= '0;
        end else begin
            r_rsp_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_sel <= w_bank_idx;
            end
            if (r_rsp_valid) begin
                r_rdata_hold <= w_rsp_data;
            end
        end
    end

    assign w_rsp_data    = w_bank_q[r_rd_sel];
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_valid ? w_rsp_data : r_rdata_hold;
    assign bus.req_ready = w_ready;
    assign bus.init_done = w_ready;

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
`ifdef GF180
            // Macro controls are active-low; one 512x8 instance per byte lane.
            for (genvar j = 0; j < NUM_BYTES; j++) begin : g_byte
                gf180_ram_512x8_wrapper u_ram (
`ifdef USE_POWER_PINS
                    .VDD  (vdd),
                    .VSS  (vss),
`endif
                    .CLK  (i_clk),
                    .CEN  (~w_bank_ce[b]),
                    .GWEN (~w_bank_we),
                    .WEN  ({8{~w_bank_mask[j]}}),
                    .A    (w_bank_addr),
                    .D    (w_bank_wdata[j*8 +: 8]),
                    .Q    (w_bank_q[b][j*8 +: 8])
                );
            end
`else
            logic [DATA_WIDTH-1:0] r_mem [ROWS];
            logic [DATA_WIDTH-1:0] r_q;

            always_ff @(posedge i_clk) begin
                if (w_bank_ce[b]) begin
                    if (w_bank_we) begin
                        for (int i = 0; i < NUM_BYTES; i++) begin
                            if (w_bank_mask[i]) begin
                                r_mem[w_bank_addr][i*8 +: 8] <= w_bank_wdata[i*8 +: 8];
                            end
                        end
                    end else begin
                        r_q <= r_mem[w_bank_addr];
                    end
                end
            end

            assign w_bank_q[b] = r_q;
`endif
        end
    endgenerate
endmodule
